// File: rtl/conv_window_mac.sv
// 5x5 window multiply-accumulate with column masking, normalising shift,
// rectification and 8-bit clamp. Processes one window row per cycle.
module conv_window_mac #(
  parameter int SHIFT = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   size,
  input  logic [199:0] matrix,
  input  logic [199:0] kernel,
  input  logic         mode,
  output logic         busy,
  output logic         done,
  output logic [7:0]   pixel_out,
  output logic         next_matrix,
  output logic         error
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_ACCUM | adding one window row per cycle
  // S_FINAL | shift, rectify, clamp, register pixel_out
  // S_DONE  | done / next_matrix pulse
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [39:0]        pix_rows  [5];
  logic [39:0]        coef_rows [5];
  logic [4:0]         col_mask;
  logic [2:0]         last_row;
  logic [2:0]         row_cnt;
  logic               mode_q;
  logic signed [20:0] acc;
  logic signed [19:0] row_sum;
  logic [7:0]         result;

  always_comb begin
    logic [39:0]        pr;
    logic [39:0]        cr;
    logic signed [16:0] pix_s;
    logic signed [16:0] coef_s;
    logic signed [16:0] prod;
    pr      = pix_rows[row_cnt];
    cr      = coef_rows[row_cnt];
    pix_s   = '0;
    coef_s  = '0;
    prod    = '0;
    row_sum = '0;
    for (int c = 0; c < 5; c++) begin
      pix_s = {9'd0, pr[c*8 +: 8]};
      // columns outside the window contribute nothing, whatever upstream sends
      coef_s  = col_mask[c] ? {{9{cr[c*8+7]}}, cr[c*8 +: 8]} : '0;
      prod    = pix_s * coef_s;
      row_sum = row_sum + {{3{prod[16]}}, prod};
    end
  end

  always_comb begin
    logic signed [20:0] s;
    s = acc >>> SHIFT;
    if (s < 21'sd0) begin
      s = mode_q ? -s : '0;
    end
    result = (s > 21'sd255) ? 8'd255 : s[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      next_matrix <= 1'b0;
      error       <= 1'b0;
      pixel_out   <= '0;
      acc         <= '0;
      row_cnt     <= '0;
      col_mask    <= '0;
      last_row    <= '0;
      mode_q      <= 1'b0;
      for (int r = 0; r < 5; r++) begin
        pix_rows[r]  <= '0;
        coef_rows[r] <= '0;
      end
    end else begin
      done        <= 1'b0;
      next_matrix <= 1'b0;
      error       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (size == 2'd2) begin
              error <= 1'b1;
            end else begin
              for (int r = 0; r < 5; r++) begin
                pix_rows[r]  <= matrix[r*40 +: 40];
                coef_rows[r] <= kernel[r*40 +: 40];
              end
              case (size)
                2'd0:    begin col_mask <= 5'b00011; last_row <= 3'd1; end
                2'd1:    begin col_mask <= 5'b00111; last_row <= 3'd2; end
                default: begin col_mask <= 5'b11111; last_row <= 3'd4; end
              endcase
              mode_q  <= mode;
              acc     <= '0;
              row_cnt <= '0;
              busy    <= 1'b1;
              state   <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          acc     <= acc + {row_sum[19], row_sum};
          row_cnt <= row_cnt + 3'd1;
          if (row_cnt == last_row) begin
            state <= S_FINAL;
          end
        end
        S_FINAL: begin
          pixel_out   <= result;
          done        <= 1'b1;
          next_matrix <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: a SHIFT=0 and a SHIFT=5 instance share
// stimulus; expected pixels and pulse timing are hand-computed.
module tb_conv_window_mac;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   size = 2'd0;
  logic [199:0] matrix = '0;
  logic [199:0] kernel = '0;
  logic         mode = 1'b0;
  logic         busy, done, next_matrix, error;
  logic [7:0]   pixel_out;
  logic         busy5, done5, next_matrix5, error5;
  logic [7:0]   pixel_out5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_window_mac #(.SHIFT(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size),
    .matrix(matrix), .kernel(kernel), .mode(mode),
    .busy(busy), .done(done), .pixel_out(pixel_out),
    .next_matrix(next_matrix), .error(error)
  );

  conv_window_mac #(.SHIFT(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size),
    .matrix(matrix), .kernel(kernel), .mode(mode),
    .busy(busy5), .done(done5), .pixel_out(pixel_out5),
    .next_matrix(next_matrix5), .error(error5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] pv, input logic [7:0] cv);
    for (int i = 0; i < 25; i++) begin
      matrix[i*8 +: 8] = pv;
      kernel[i*8 +: 8] = cv;
    end
  endtask

  task automatic set_pk(input int r, input int c, input logic [7:0] pv, input logic [7:0] cv);
    matrix[(5*r+c)*8 +: 8] = pv;
    kernel[(5*r+c)*8 +: 8] = cv;
  endtask

  // Start one window, scramble the inputs after accept, and track the pulses.
  task automatic run_window(input string tag, input logic [1:0] sz, input logic md,
                            input int n, input logic [7:0] exp0, input logic [7:0] exp5,
                            input bit extra);
    int done_at;
    int n_done;
    int n_next;
    logic [7:0]   pre;
    logic [199:0] m_save;
    logic [199:0] k_save;
    pre = pixel_out;
    m_save = matrix;
    k_save = kernel;
    @(negedge clk);
    size = sz; mode = md; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    matrix = ~matrix;
    kernel = ~kernel;
    mode = ~md;
    check({tag, " busy after accept"}, busy, 1);
    done_at = -1; n_done = 0; n_next = 0;
    for (int k = 1; k <= n + 3; k++) begin
      if (extra && k == 1) start = 1'b1;
      @(posedge clk); #1;
      if (extra && k == 1) start = 1'b0;
      if (done) begin
        n_done++;
        done_at = k;
      end
      if (next_matrix) n_next++;
      if (k == n) check({tag, " pixel held before done"}, pixel_out, pre);
      if (k == n + 1) check({tag, " busy in done cycle"}, busy, 1);
      if (k == n + 2) check({tag, " busy after done"}, busy, 0);
    end
    check({tag, " done edge"}, done_at, n + 1);
    check({tag, " done count"}, n_done, 1);
    check({tag, " next_matrix count"}, n_next, 1);
    check({tag, " pixel shift0"}, pixel_out, exp0);
    check({tag, " pixel shift5"}, pixel_out5, exp5);
    matrix = m_save;
    kernel = k_save;
  endtask

  initial begin
    int seen;

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset next_matrix", next_matrix, 0);
    check("reset error", error, 0);
    check("reset pixel", pixel_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 3x3 box: 9 * 10 = 90; 90 >>> 5 = 2; extra start at T+2 ignored
    fill(8'd10, 8'd0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        kernel[(5*r+c)*8 +: 8] = 8'd1;
    run_window("box3", 2'd1, 1'b0, 3, 8'd90, 8'd2, 1'b1);

    // 5x5 saturation: 25 * 255 = 6375 -> 255; 6375 >>> 5 = 199
    fill(8'd255, 8'd1);
    run_window("sat5", 2'd3, 1'b0, 5, 8'd255, 8'd199, 1'b0);

    // Sobel-x: sum = -200; mode0 -> 0, mode1 -> 200; -200 >>> 5 = -7 -> 7
    fill(8'd0, 8'd0);
    for (int r = 0; r < 3; r++) begin
      set_pk(r, 0, 8'd50, (r == 1) ? 8'hFE : 8'hFF);
      set_pk(r, 2, 8'd0, (r == 1) ? 8'd2 : 8'd1);
    end
    run_window("sobel m0", 2'd1, 1'b0, 3, 8'd0, 8'd0, 1'b0);
    run_window("sobel m1", 2'd1, 1'b1, 3, 8'd200, 8'd7, 1'b0);

    // 2x2 masking: outside positions 255 / 127 must not contribute
    fill(8'd255, 8'd127);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        set_pk(r, c, 8'd4, 8'd1);
    run_window("mask2", 2'd0, 1'b0, 2, 8'd16, 8'd0, 1'b0);

    // illegal size
    @(negedge clk);
    size = 2'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal error pulse", error, 1);
    check("illegal busy", busy, 0);
    check("illegal done", done, 0);
    check("illegal next_matrix", next_matrix, 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (error || busy || done || next_matrix) seen++;
    end
    check("illegal quiet after pulse", seen, 0);
    check("illegal pixel held", pixel_out, 16);

    // reset during 5x5 ACCUM at T+3
    fill(8'd255, 8'd1);
    @(negedge clk);
    size = 2'd3; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort next_matrix", next_matrix, 0);
    check("abort pixel", pixel_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || next_matrix || busy) seen++;
    end
    check("abort no done", seen, 0);

    fill(8'd10, 8'd0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        kernel[(5*r+c)*8 +: 8] = 8'd1;
    run_window("box3 after reset", 2'd1, 1'b0, 3, 8'd90, 8'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Multi-cycle multiply-accumulate stage directly downstream of the line buffer. It latches one 5x5 pixel window (`matrix`) together with a signed coefficient kernel and accumulates one window row per cycle. It then normalises, rectifies and clamps the sum to an 8-bit output pixel. On completion it pulses `next_matrix` back to the line buffer so the window advances one column.

## Interface
Parameters:
- `SHIFT`, default 0: arithmetic right shift applied to the final sum (kernel normalisation), legal range 0..15.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to process the current window; accepted only in IDLE.
- `size`  in  2  window size: 0 = 2x2, 1 = 3x3, 3 = 5x5, 2 = illegal.
- `matrix`  in  200  25 unsigned 8-bit pixels; row r, column c at bits [(5r+c)*8 +: 8].
- `kernel`  in  200  25 signed two's-complement 8-bit coefficients, same layout as `matrix`.
- `mode`  in  1  0 = clamp negative results to 0; 1 = take absolute value, then clamp.
- `busy`  out  1  high while a window is being processed.
- `done`  out  1  one-cycle pulse; `pixel_out` is valid from this cycle.
- `pixel_out`  out  8  result pixel; holds until the next `done`.
- `next_matrix`  out  1  one-cycle pulse, coincident with `done`; advances the line buffer.
- `error`  out  1  one-cycle pulse on a start with illegal `size`.

## Operation
- States: IDLE, ACCUM, FINAL, DONE.
- IDLE, `start`=1, legal size:
  - latch `matrix`, `kernel`, `size` and `mode` into internal registers;
  - clear the accumulator and the row counter;
  - go to ACCUM.
- Upstream inputs may change freely after the accept cycle.
- IDLE, `start`=1, size=2: pulse `error` next cycle and stay in IDLE. No accumulation, no `next_matrix`, `pixel_out` unchanged.
- Window extent N is 2, 3 or 5 for size 0, 1 or 3.
- ACCUM, one row r per cycle, r = 0..N-1:
  - add the sum of the five products pixel[r][c] x coeff[r][c] to the accumulator;
  - any coefficient with c >= N is forced to 0 inside this block, independent of upstream zeroing;
  - after row N-1, go to FINAL.
- Arithmetic:
  - each product is pixel zero-extended times coefficient sign-extended, giving 17-bit signed;
  - accumulator is 21-bit signed; worst case 25 x 255 x 128 = 816000 cannot overflow.
- FINAL:
  - s = accumulator >>> SHIFT (arithmetic shift);
  - if mode=1 and s<0, s = -s; if mode=0 and s<0, s = 0;
  - s>255 gives 255; register the result into `pixel_out`;
  - go to DONE.
- DONE: `done`=1 and `next_matrix`=1 for exactly this cycle, then return to IDLE.
- `start` while busy is ignored; no queuing.

## Timing
- Reset values: `busy`, `done`, `next_matrix`, `error` and `pixel_out` are all 0. State is IDLE, accumulator and row counter are 0.
- `start` is sampled at edge T: `busy` rises after T and stays high through the DONE cycle.
- ACCUM occupies cycles T+1..T+N, FINAL is cycle T+N+1, and `done`/`next_matrix` are high in cycle T+N+2.
- Latency from start to done is 4, 5 or 7 cycles for 2x2, 3x3 or 5x5.
- `busy` falls after the DONE cycle, so the earliest next start is sampled at edge T+N+3.
- `pixel_out` changes only on the edge that raises `done`.
- `reset_n` low at any point, including mid-ACCUM:
  - all outputs go to 0 immediately (asynchronous);
  - no `done` or `next_matrix` is generated for the aborted window;
  - the first start after reset release is accepted normally.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **3x3 box filter:** 3x3, mode 0, SHIFT=0; window pixels all 10, kernel 3x3 all 1, start at T.
  - Required: `pixel_out`=90, with `done` and `next_matrix` high only at T+5.
  - A second `start` at T+2 is ignored.
- **5x5 saturation:** 5x5; pixels all 255, kernel all 1.
  - Required: sum 6375 clamps to `pixel_out`=255, `done` at T+7.
  - With SHIFT=5, rerun gives 199.
- **Sobel-x rectification:** 3x3 kernel [-1 0 1; -2 0 2; -1 0 1]; left column 50, right column 0.
  - Required: mode 0 gives `pixel_out`=0; mode 1 gives 200.
- **2x2 masking:** 2x2; window pixels 4, kernel 1 in the 2x2 window.
  - All other matrix positions are 255 and all other kernel positions are 127.
  - Required: `pixel_out`=16, `done` at T+4.
- **Illegal size:** start with size=2.
  - Required: `error`=1 at T+1 only; `busy`, `done` and `next_matrix` stay 0; `pixel_out` unchanged.
- **Reset mid-operation:** assert `reset_n`=0 during the 5x5 ACCUM at T+3.
  - Required: outputs are 0 immediately and no `done` appears.
  - After release, a new 3x3 start completes normally at +5.
